// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART receive path and the CRC-tracked transmit
// path.
//   rx_state_t  receive FSM encoding (IDLE, START, DATA, STOP)
//   CRC8_POLY   CRC-8 generator polynomial (x^8 + x^2 + x + 1, MSB first)
//   CRC8_INIT   CRC-8 start value, also the value restored by a clear
//   DATA_BITS   payload bits per frame
//   STOP_BITS   stop bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/crc8_byte_update.sv
// -----------------------------------------------------------------------------
// crc8_byte_update
//
// Purely combinational CRC-8 step: folds one byte into a running CRC, MSB
// first, no reflection, no final XOR. Shared by the UART receiver and the
// transmitter so both ends compute an identical checksum.
//
// Ports
//   crc       in  8  current CRC value
//   data      in  8  byte to fold in
//   crc_next  out 8  CRC after the byte
// -----------------------------------------------------------------------------
module crc8_byte_update
    import uart_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    // stage[0] is the byte XORed into the CRC; each following stage is one
    // bit of the shift-and-conditionally-XOR long division.
    logic [7:0] stage [0:8];

    assign stage[0] = crc ^ data;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_bit
            assign stage[gi + 1] = stage[gi][7]
                                 ? ({stage[gi][6:0], 1'b0} ^ CRC8_POLY)
                                 :  {stage[gi][6:0], 1'b0};
        end
    endgenerate

    assign crc_next = stage[8];

endmodule

// File: rtl/uart_receiver_system.sv
// -----------------------------------------------------------------------------
// uart_receiver_system
//
// 8N1 UART receiver with a ready/acknowledge byte handshake, framing and
// overrun error reporting, and a running CRC-8 over every accepted byte.
//
// Build option
//   UART_RX_CRC_EN  when defined, the CRC-8 register and update logic are
//                   built. When undefined, crc8 reads 0x00 and clear_crc is
//                   ignored; everything else is identical.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per serial bit (minimum 4)
//
// Ports
//   clock          in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high
//   data_in        in   1  asynchronous serial line, idle high
//   acknowledge    in   1  consumer has taken data_out
//   clear_crc      in   1  single-cycle pulse, zeroes crc8
//   data_out       out  8  last accepted byte
//   data_ready     out  1  high while data_out is unconsumed
//   framing_error  out  1  one-cycle pulse on a low stop bit
//   overrun        out  1  sticky; a byte arrived while data_ready was high
//   crc8           out  8  running CRC-8 over accepted bytes
//   busy           out  1  receive FSM not idle
// -----------------------------------------------------------------------------
module uart_receiver_system
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    input  logic       acknowledge,
    input  logic       clear_crc,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic [7:0] crc8,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // The start bit is re-checked half a bit after the falling edge, which
    // places every later sample near the middle of its bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------------------------------------------------------
    // Input synchronizer (idle-high, so it resets to 1)
    // ---------------------------------------------------------------
    logic sync1_reg;
    logic rx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            rx_reg    <= 1'b1;
        end else begin
            sync1_reg <= data_in;
            rx_reg    <= sync1_reg;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    rx_state_t        state_reg,   state_next;
    logic [CNT_W-1:0] count_reg,   count_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             accept_stb;
    logic             frame_err_stb;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        accept_stb    = 1'b0;
        frame_err_stb = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_reg) begin
                    count_next = HALF_LOAD;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (count_reg == '0) begin
                    if (!rx_reg) begin
                        count_next   = FULL_LOAD;
                        bit_idx_next = '0;
                        state_next   = ST_DATA;
                    end else begin
                        // Line went back high before mid-bit: noise, not a
                        // start bit. Drop it silently.
                        state_next = ST_IDLE;
                    end
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (count_reg == '0) begin
                    // LSB arrives first, so shift in from the top.
                    shift_next = {rx_reg, shift_reg[7:1]};
                    count_next = FULL_LOAD;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (count_reg == '0) begin
                    state_next = ST_IDLE;
                    if (rx_reg) begin
                        accept_stb = 1'b1;
                    end else begin
                        frame_err_stb = 1'b1;
                    end
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Byte handshake and error flags
    // ---------------------------------------------------------------
    logic [7:0] data_out_reg;
    logic       data_ready_reg;
    logic       framing_error_reg;
    logic       overrun_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_reg      <= 8'h00;
            data_ready_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            framing_error_reg <= frame_err_stb;

            // A consumed byte clears the overrun flag; a fresh overrun in
            // the same cycle cannot happen because acknowledge frees the slot.
            if (acknowledge && data_ready_reg) begin
                overrun_reg <= 1'b0;
            end

            if (accept_stb) begin
                data_ready_reg <= 1'b1;
                if (!data_ready_reg || acknowledge) begin
                    data_out_reg <= shift_reg;
                end else begin
                    // Slot still occupied: keep the old byte, drop the new.
                    overrun_reg <= 1'b1;
                end
            end else if (acknowledge && data_ready_reg) begin
                data_ready_reg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Running CRC-8 (optional)
    // ---------------------------------------------------------------
`ifdef UART_RX_CRC_EN
    logic [7:0] crc_reg;
    logic [7:0] crc_upd;

    crc8_byte_update u_crc8 (
        .crc      (crc_reg),
        .data     (shift_reg),
        .crc_next (crc_upd)
    );

    // Overrun-discarded bytes still count: the sender's checksum covers
    // everything that went over the wire with a valid stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_reg <= CRC8_INIT;
        end else if (clear_crc) begin
            crc_reg <= CRC8_INIT;
        end else if (accept_stb) begin
            crc_reg <= crc_upd;
        end
    end

    assign crc8 = crc_reg;
`else
    logic unused_clear_crc;
    assign unused_clear_crc = clear_crc;
    assign crc8             = 8'h00;
`endif

    assign data_out      = data_out_reg;
    assign data_ready    = data_ready_reg;
    assign framing_error = framing_error_reg;
    assign overrun       = overrun_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver_system.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver_system
//
// Directed bench for uart_receiver_system at CLKS_PER_BIT = 16. Frames are
// driven one bit per 16 falling clock edges. For a frame whose start bit is
// driven at falling edge n = 0, the stop bit is sampled on the rising edge
// right after falling edge n = 154, so the accept / framing-error result is
// visible from falling edge n = 155 on. Expected CRC values apply only when
// UART_RX_CRC_EN is defined; otherwise crc8 must read 0x00.
// -----------------------------------------------------------------------------
module tb_uart_receiver_system;

    localparam int CPB = 16;
    localparam int FRAME_CYCLES = 10 * CPB;
    localparam int GAP_CYCLES = 2 * CPB;

`ifdef UART_RX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b1;
    logic       acknowledge = 1'b0;
    logic       clear_crc = 1'b0;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
    logic [7:0] crc8;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int fe_count = 0;

    // Snapshots taken by send_frame around the stop-bit decision.
    logic dr_at_154, dr_at_155;
    logic fe_at_154, fe_at_155, fe_at_156;

    uart_receiver_system #(.CLKS_PER_BIT(CPB)) dut (
        .clock         (clk),
        .reset         (reset),
        .data_in       (data_in),
        .acknowledge   (acknowledge),
        .clear_crc     (clear_crc),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .crc8          (crc8),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // Reference CRC-8 (poly 0x07, MSB first), bit-serial long division.
    function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_crc(input logic [7:0] v);
        return CRC_ON ? v : 8'h00;
    endfunction

    // Drive one full 8N1 frame, optionally with clear_crc on the accept cycle,
    // followed by an idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic clr);
        for (int n = 0; n < FRAME_CYCLES; n++) begin
            @(negedge clk);
            if (n == 154) begin dr_at_154 = data_ready; fe_at_154 = framing_error; end
            if (n == 155) begin dr_at_155 = data_ready; fe_at_155 = framing_error; end
            if (n == 156) fe_at_156 = framing_error;
            if (n < CPB)            data_in = 1'b0;
            else if (n < 9 * CPB)   data_in = b[(n - CPB) / CPB];
            else                    data_in = stop_bit;
            clear_crc = clr && (n == 154);
        end
        @(negedge clk);
        data_in = 1'b1;
        clear_crc = 1'b0;
        repeat (GAP_CYCLES) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk); acknowledge = 1'b1;
        @(negedge clk); acknowledge = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_crc = 1'b1;
        @(negedge clk); clear_crc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_framing_error: got %b want 0", framing_error); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if (crc8 !== 8'h00) begin miscompares++; $display("FAIL reset_crc8: got %h want 00", crc8); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        int fe0;
        fe0 = fe_count;
        send_frame(8'h31, 1'b1, 1'b0);
        vectors++; if (dr_at_154 !== 1'b0) begin miscompares++; $display("FAIL latency_early: data_ready got %b want 0 at n=154", dr_at_154); end
        vectors++; if (dr_at_155 !== 1'b1) begin miscompares++; $display("FAIL latency_on_time: data_ready got %b want 1 at n=155", dr_at_155); end
        vectors++; if (data_out !== 8'h31) begin miscompares++; $display("FAIL single_data_out: got %h want 31", data_out); end
        vectors++; if (crc8 !== exp_crc(8'h97)) begin miscompares++; $display("FAIL single_crc8: got %h want %h", crc8, exp_crc(8'h97)); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL single_overrun: got %b want 0", overrun); end
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL single_no_ferr: framing pulses got %0d want %0d", fe_count, fe0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        pulse_ack();
        @(negedge clk);
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL single_ack_clears: data_ready got %b want 0", data_ready); end
        $display("test_single_byte: rx %h crc %h", data_out, crc8);
    endtask

    task automatic test_check_string();
        logic [7:0] msg [0:8];
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
        msg[5] = 8'h36; msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
        pulse_clear();
        @(negedge clk);
        vectors++; if (crc8 !== 8'h00) begin miscompares++; $display("FAIL clear_crc_pulse: got %h want 00", crc8); end
        for (int i = 0; i < 9; i++) begin
            send_frame(msg[i], 1'b1, 1'b0);
            vectors++; if (data_out !== msg[i] || data_ready !== 1'b1) begin
                miscompares++; $display("FAIL string_byte%0d: got %h/%b want %h/1", i, data_out, data_ready, msg[i]);
            end
            $display("test_check_string: byte %0d rx %h", i, data_out);
            pulse_ack();
        end
        vectors++; if (crc8 !== exp_crc(8'hF4)) begin miscompares++; $display("FAIL string_crc8: got %h want %h", crc8, exp_crc(8'hF4)); end
    endtask

    task automatic test_framing_error();
        logic [7:0] crc_before;
        logic [7:0] dout_before;
        int fe0;
        crc_before = crc8;
        dout_before = data_out;
        fe0 = fe_count;
        send_frame(8'h55, 1'b0, 1'b0);
        vectors++; if (fe_at_154 !== 1'b0 || fe_at_155 !== 1'b1 || fe_at_156 !== 1'b0) begin
            miscompares++; $display("FAIL ferr_pulse_shape: got %b%b%b want 010", fe_at_154, fe_at_155, fe_at_156);
        end
        vectors++; if (fe_count !== fe0 + 1) begin miscompares++; $display("FAIL ferr_count: got %0d want %0d", fe_count, fe0 + 1); end
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL ferr_no_ready: got %b want 0", data_ready); end
        vectors++; if (data_out !== dout_before) begin miscompares++; $display("FAIL ferr_data_out_kept: got %h want %h", data_out, dout_before); end
        vectors++; if (crc8 !== crc_before) begin miscompares++; $display("FAIL ferr_crc_kept: got %h want %h", crc8, crc_before); end
        $display("test_framing_error: pulses %0d", fe_count - fe0);
    endtask

    task automatic test_overrun();
        logic [7:0] want;
        pulse_clear();
        send_frame(8'hA1, 1'b1, 1'b0);
        send_frame(8'hB2, 1'b1, 1'b0);
        want = exp_crc(crc_model(crc_model(8'h00, 8'hA1), 8'hB2));
        vectors++; if (data_out !== 8'hA1) begin miscompares++; $display("FAIL overrun_keeps_old: got %h want a1", data_out); end
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL overrun_ready: got %b want 1", data_ready); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        vectors++; if (crc8 !== want) begin miscompares++; $display("FAIL overrun_crc_both: got %h want %h", crc8, want); end
        pulse_ack();
        @(negedge clk);
        vectors++; if (data_ready !== 1'b0 || overrun !== 1'b0) begin
            miscompares++; $display("FAIL overrun_ack_clears: ready/overrun got %b/%b want 0/0", data_ready, overrun);
        end
        pulse_ack();
        @(negedge clk);
        vectors++; if (data_ready !== 1'b0 || data_out !== 8'hA1) begin
            miscompares++; $display("FAIL idle_ack_noop: got %b/%h want 0/a1", data_ready, data_out);
        end
        $display("test_overrun: rx %h crc %h", data_out, crc8);
    endtask

    task automatic test_glitch();
        logic [7:0] crc_before;
        logic [7:0] dout_before;
        logic busy_seen;
        int fe0;
        crc_before = crc8;
        dout_before = data_out;
        fe0 = fe_count;
        busy_seen = 1'b0;
        @(negedge clk); data_in = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); data_in = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL glitch_start_seen: busy got %b want 1", busy_seen); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_back_idle: busy got %b want 0", busy); end
        vectors++; if (data_ready !== 1'b0 || data_out !== dout_before || crc8 !== crc_before || overrun !== 1'b0) begin
            miscompares++; $display("FAIL glitch_outputs_kept: got %b/%h/%h/%b want 0/%h/%h/0", data_ready, data_out, crc8, overrun, dout_before, crc_before);
        end
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL glitch_no_ferr: got %0d want %0d", fe_count, fe0); end
        $display("test_glitch: busy_seen %b", busy_seen);
    endtask

    task automatic test_clear_on_accept();
        send_frame(8'h42, 1'b1, 1'b1);
        vectors++; if (crc8 !== 8'h00) begin miscompares++; $display("FAIL clear_on_accept_crc: got %h want 00", crc8); end
        vectors++; if (data_out !== 8'h42 || data_ready !== 1'b1) begin
            miscompares++; $display("FAIL clear_on_accept_byte: got %h/%b want 42/1", data_out, data_ready);
        end
        $display("test_clear_on_accept: rx %h crc %h", data_out, crc8);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] want;
        // data_ready is still high from the previous test, so reset must clear it.
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n < CPB) data_in = 1'b0;
            else         data_in = n[4] ? 1'b1 : 1'b0;
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midframe_busy: got %b want 1", busy); end
        @(negedge clk); reset = 1'b1; data_in = 1'b1;
        @(negedge clk); reset = 1'b0;
        vectors++; if (data_out !== 8'h00 || data_ready !== 1'b0 || framing_error !== 1'b0 ||
                       overrun !== 1'b0 || crc8 !== 8'h00 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midframe_reset_values: got %h/%b/%b/%b/%h/%b want 00/0/0/0/00/0",
                                    data_out, data_ready, framing_error, overrun, crc8, busy);
        end
        repeat (GAP_CYCLES) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b0);
        want = exp_crc(crc_model(8'h00, 8'h7E));
        vectors++; if (data_out !== 8'h7E || data_ready !== 1'b1) begin
            miscompares++; $display("FAIL after_reset_byte: got %h/%b want 7e/1", data_out, data_ready);
        end
        vectors++; if (crc8 !== want) begin miscompares++; $display("FAIL after_reset_crc: got %h want %h", crc8, want); end
        $display("test_reset_mid_frame: rx %h crc %h", data_out, crc8);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_check_string();
        test_framing_error();
        test_overrun();
        test_glitch();
        test_clear_on_accept();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
